fsmc_fifo_regs: RTL
===================

# fsmc_fifo_regs

Register-mapped FIFO peripheral that sits directly downstream of the clocked FSMC bus slave. It consumes the slave's `do_write`/`w_data`/`rw_adr` strobes and returns `read_data`. The STM32 can push words into a FIFO, pop them back, inspect level and status flags, and flush. It gives the bus path a stateful read side effect (pop on read) to exercise, and exposes the FIFO level for LED debug.

## Interface
Parameters:
- `ADRW`, default 2: bus address width; must be ≥ 2.
- `DATW`, default 3: bus data width and FIFO word width.
- `DEPTH_LOG2`, default 2: FIFO depth is 2^DEPTH_LOG2 words.

Ports:
- `clk`, in, 1: system clock (PLL output). One clock domain only.
- `rst`, in, 1: synchronous, active-high reset.
- `do_write`, in, 1: one-cycle write strobe from the bus slave.
- `do_read`, in, 1: one-cycle read strobe from the bus slave.
- `rw_adr`, in, ADRW: register address, stable while either strobe is high.
- `w_data`, in, DATW: write data, valid with `do_write`.
- `read_data`, out, DATW: combinational read data for `rw_adr`.
- `level`, out, DEPTH_LOG2+1: current fill count, for debug/LEDs.

## Operation
Register map uses `rw_adr[1:0]`; upper address bits are ignored.
- 0, DATA
  - Write: push `w_data`.
  - Read: `read_data` = head word; `do_read` pops it.
- 1, STATUS
  - Read: bit0 = empty, bit1 = full, bit2 = sticky error; remaining bits are 0.
  - Write: any value clears sticky error.
- 2, LEVEL
  - Read: `level`, zero-extended or truncated to DATW.
  - Write: ignored.
- 3, CTRL
  - Write: any value flushes the FIFO (rd_ptr = wr_ptr = 0, level = 0). Sticky error is unchanged.
  - Read: returns 0.

Storage and pointers:
- Storage is a 2^DEPTH_LOG2 × DATW register array.
- `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits wide and wrap modulo depth.
- Count is DEPTH_LOG2+1 bits wide. empty = (count == 0); full = (count == 2^DEPTH_LOG2).

Push and pop rules:
- Push to full FIFO: data dropped, pointers unchanged, sticky error set.
- Pop from empty FIFO: pointers unchanged, sticky error set. `read_data` at DATA while empty is 0.
- Pop from non-empty FIFO: `rd_ptr` advances and count decrements.

Simultaneous events (not produced by the bus slave, but defined):
- `do_write` and `do_read` in the same cycle act independently, each using its own decode of `rw_adr`.
- DATA push and DATA pop together: push is accepted even when full, pop is accepted even when the FIFO holds one word; count is unchanged. If empty, the pop is an underflow (error set) and the push succeeds.
- Flush together with a pop: flush wins; no error from that pop.
- Error set and error clear in the same cycle: set wins.

Reset:
- Pointers, count and error clear to 0. Storage contents are not reset.
- Reset mid-transaction discards all state. Strobes seen while `rst` is high are ignored.

## Timing
- `read_data` is purely combinational from `rw_adr` and current state.
  - The bus slave samples it on the same edge where it sees `do_read` high, so the popped word is the value presented before that edge.
  - The pop takes effect at that edge; the next head is visible the following cycle.
- Push latency: a word written at edge N is readable at DATA, and reflected in `level`/STATUS, from cycle N+1.
- Flush and error clear take effect at the strobe edge and are visible the next cycle.
- Outputs after reset:
  - `level` = 0.
  - STATUS read = 3'b001 (empty).
  - `read_data` = 0 for addresses 0 and 3; for address 2 it is `level` (0).
- No back-pressure. Every strobe completes in one cycle, and back-to-back strobes on consecutive cycles must work.

## Test plan
- Reset, then read STATUS and LEVEL → 3'b001 and 0.
- Push 5, 2, 7, then pop three times → `read_data` 5, 2, 7; `level` 3→2→1→0; STATUS ends 3'b001.
- Push 1, 2, 3, 4 (full), then push 6 → STATUS 3'b110, `level` 4. Pops return 1, 2, 3, 4. Write STATUS → 3'b001.
- Pop on empty → `read_data` 0, STATUS 3'b101, `level` stays 0.
- Push 2 words, pop 1, push 3 more → wrap-around: pops return the correct order; `level` 4, full at pointer wrap.
- Push 3 words, write CTRL, read STATUS → 3'b001. Push 3, then assert `rst` for one cycle mid-sequence → `level` 0, error 0.

Source files
------------

// File: rtl/fsmc_fifo_regs.sv
// Register-mapped FIFO behind the FSMC bus slave: DATA push/pop, STATUS flags,
// LEVEL readback and CTRL flush, with a sticky overflow/underflow error bit.
module fsmc_fifo_regs #(
    parameter int ADRW       = 2,
    parameter int DATW       = 3,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  do_write,
    input  logic                  do_read,
    input  logic [ADRW-1:0]       rw_adr,
    input  logic [DATW-1:0]       w_data,
    output logic [DATW-1:0]       read_data,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int SW    = (DATW > 3) ? DATW : 3;
    localparam int XW    = (DATW > LW) ? DATW : LW;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_LEVEL  = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic [DATW-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q, count_d;
    logic                  err_q, err_d;

    logic [1:0] reg_sel;
    logic       empty, full;
    logic       push, pop, flush, err_clr;
    logic       push_ok, pop_ok, overflow, underflow;
    logic       unused_adr;

    assign reg_sel    = rw_adr[1:0];
    assign unused_adr = ^rw_adr;

    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));

    assign push    = do_write && (reg_sel == A_DATA);
    assign err_clr = do_write && (reg_sel == A_STATUS);
    assign flush   = do_write && (reg_sel == A_CTRL);
    assign pop     = do_read  && (reg_sel == A_DATA);

    // A concurrent pop frees the slot, so a push into a full FIFO still lands.
    assign pop_ok    = pop && !empty && !flush;
    assign push_ok   = push && (!full || pop_ok);
    assign overflow  = push && !push_ok;
    assign underflow = pop && empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end
            count_d = count_q + LW'(push_ok) - LW'(pop_ok);
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (overflow || underflow) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    logic [SW-1:0] status_ext;
    logic [XW-1:0] level_ext;

    assign status_ext = SW'({err_q, full, empty});
    assign level_ext  = XW'(count_q);
    assign level      = count_q;

    always_comb begin
        read_data = '0;
        case (reg_sel)
            A_DATA:   read_data = empty ? '0 : mem_q[rd_ptr_q];
            A_STATUS: read_data = status_ext[DATW-1:0];
            A_LEVEL:  read_data = level_ext[DATW-1:0];
            default:  read_data = '0;
        endcase
    end

endmodule
